vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between two requesters:
  - the pixel-fetch path that feeds char_blender (character codes and attributes);
  - the host register/bus interface that writes and reads screen text.
- Grants at most one memory access per clock; video has priority so active scan-out never stalls.
- Tags each in-flight read so return data reaches the correct requester.
- Sits between vga_core timing / char_blender fetch logic and the VRAM macro, in the clk_pix domain.

---
 rtl/ogege_pkg.sv | 23 ++
 rtl/vram_ret_pipe.sv | 72 +++++++
 rtl/vram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ogege_pkg.sv
// -----------------------------------------------------------------------------
// ogege_pkg
//
// Shared definitions for the VRAM access path of the text-mode video block.
//
//   VRAM_AW / VRAM_DW : default VRAM address and data widths.
//   WAIT_W            : width of the host wait counter (saturates at all-ones).
//   owner_t           : tag carried alongside every issued access so returning
//                       read data can be steered to the requester that asked.
// -----------------------------------------------------------------------------
package ogege_pkg;

    localparam int VRAM_AW = 12;
    localparam int VRAM_DW = 16;
    localparam int WAIT_W  = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

endpackage : ogege_pkg

// File: rtl/vram_ret_pipe.sv
// -----------------------------------------------------------------------------
// vram_ret_pipe
//
// Return path of the VRAM arbiter. Carries the owner tag of each issued access
// through two register stages so that it lines up with the read data coming
// back from the synchronous VRAM, then steers that data to the requester that
// issued the read.
//
// Ports:
//   clk_i          in   pixel clock
//   rst_i          in   synchronous reset, active high (flushes in-flight tags)
//   own_i          in   owner of the access being granted at this edge
//                       (OWN_NONE for idle cycles and for writes)
//   mem_rdata_i    in   VRAM read data, valid the cycle after the enable
//   vid_rvalid_o   out  one-cycle pulse: vid_rdata_o carries fresh read data
//   vid_rdata_o    out  video read data, holds while vid_rvalid_o is low
//   host_rvalid_o  out  one-cycle pulse: host_rdata_o carries fresh read data
//   host_rdata_o   out  host read data, holds while host_rvalid_o is low
// -----------------------------------------------------------------------------
module vram_ret_pipe
    import ogege_pkg::*;
#(
    parameter int DW = VRAM_DW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  owner_t        own_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          vid_rvalid_o,
    output logic [DW-1:0] vid_rdata_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o
);

    owner_t        r_own_p1;
    owner_t        r_own_p2;
    logic          r_vid_rvalid_p3;
    logic [DW-1:0] r_vid_rdata_p3;
    logic          r_host_rvalid_p3;
    logic [DW-1:0] r_host_rdata_p3;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_own_p1         <= OWN_NONE;
            r_own_p2         <= OWN_NONE;
            r_vid_rvalid_p3  <= 1'b0;
            r_vid_rdata_p3   <= '0;
            r_host_rvalid_p3 <= 1'b0;
            r_host_rdata_p3  <= '0;
        end else begin
            // p1: command is on the VRAM pins
            r_own_p1 <= own_i;
            // p2: VRAM has sampled the command, read data is on mem_rdata_i
            r_own_p2 <= r_own_p1;
            // p3: capture and steer the returned word
            r_vid_rvalid_p3  <= (r_own_p2 == OWN_VID);
            r_host_rvalid_p3 <= (r_own_p2 == OWN_HOST);
            if (r_own_p2 == OWN_VID) begin
                r_vid_rdata_p3 <= mem_rdata_i;
            end
            if (r_own_p2 == OWN_HOST) begin
                r_host_rdata_p3 <= mem_rdata_i;
            end
        end
    end

    assign vid_rvalid_o  = r_vid_rvalid_p3;
    assign vid_rdata_o   = r_vid_rdata_p3;
    assign host_rvalid_o = r_host_rvalid_p3;
    assign host_rdata_o  = r_host_rdata_p3;

endmodule : vram_ret_pipe

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous VRAM between the pixel-fetch path (video)
// and the host register/bus interface. At most one access is granted per
// clock; video has priority so scan-out never stalls. Every grant is
// registered, so the ack and the VRAM command appear together in the cycle
// after the request was sampled. Reads return through vram_ret_pipe with a
// fixed latency: request sampled at edge E -> rvalid visible after edge E+2.
//
// Optional feature (compile-time macro OGEGE_VRAM_FAIR_EN):
//   When defined, a host request that has waited HOST_MAX_WAIT cycles takes
//   the next slot even if video is requesting; video sees no ack that cycle
//   and must hold its request. When undefined, video priority is strict and
//   the host may starve during active display.
//
// Ports:
//   clk_i          in   pixel clock
//   rst_i          in   synchronous reset, active high
//   vid_req_i      in   video read request
//   vid_addr_i     in   video read address
//   vid_ack_o      out  video request accepted (visible cycle after sampling)
//   vid_rvalid_o   out  video read data valid
//   vid_rdata_o    out  video read data
//   host_req_i     in   host request, held until acked
//   host_we_i      in   1 = write, 0 = read
//   host_addr_i    in   host address
//   host_wdata_i   in   host write data
//   host_ack_o     out  host request accepted (one-cycle pulse)
//   host_rvalid_o  out  host read data valid
//   host_rdata_o   out  host read data
//   mem_en_o       out  VRAM enable
//   mem_we_o       out  VRAM write enable
//   mem_addr_o     out  VRAM address (holds on idle cycles)
//   mem_wdata_o    out  VRAM write data (zero for reads)
//   mem_rdata_i    in   VRAM read data, valid the cycle after a read enable
//   host_wait_o    out  saturating count of cycles the host request waited
// -----------------------------------------------------------------------------
module vram_arbiter
    import ogege_pkg::*;
#(
    parameter int AW            = VRAM_AW,
    parameter int DW            = VRAM_DW,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vid_req_i,
    input  logic [AW-1:0]     vid_addr_i,
    output logic              vid_ack_o,
    output logic              vid_rvalid_o,
    output logic [DW-1:0]     vid_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [AW-1:0]     host_addr_i,
    input  logic [DW-1:0]     host_wdata_i,
    output logic              host_ack_o,
    output logic              host_rvalid_o,
    output logic [DW-1:0]     host_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i,
    output logic [WAIT_W-1:0] host_wait_o
);

    if (HOST_MAX_WAIT < 1 || HOST_MAX_WAIT > 255) begin : g_bad_max_wait
        $error("vram_arbiter: HOST_MAX_WAIT must lie in 1..255");
    end

    // Wait counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic              r_vid_ack_p1;
    logic              r_host_ack_p1;
    logic              r_mem_en_p1;
    logic              r_mem_we_p1;
    logic [AW-1:0]     r_mem_addr_p1;
    logic [DW-1:0]     r_mem_wdata_p1;
    logic [WAIT_W-1:0] r_host_wait;

    logic              w_host_elig;
    logic              w_host_force;
    logic              w_grant_vid;
    logic              w_grant_host;
    owner_t            w_own;

    // A host request whose ack is currently visible has already been served;
    // the requester may already be presenting its next request, which is only
    // considered from the following edge on.
    assign w_host_elig = host_req_i && !r_host_ack_p1;

`ifdef OGEGE_VRAM_FAIR_EN
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(HOST_MAX_WAIT);
    assign w_host_force = w_host_elig && (r_host_wait >= MAX_WAIT_C);
`else
    assign w_host_force = 1'b0;
`endif

    always_comb begin
        w_grant_vid  = 1'b0;
        w_grant_host = 1'b0;
        w_own        = OWN_NONE;
        if (w_host_force) begin
            w_grant_host = 1'b1;
        end else if (vid_req_i) begin
            w_grant_vid = 1'b1;
        end else if (w_host_elig) begin
            w_grant_host = 1'b1;
        end
        // Writes carry no tag: nothing comes back for them.
        if (w_grant_vid) begin
            w_own = OWN_VID;
        end else if (w_grant_host && !host_we_i) begin
            w_own = OWN_HOST;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vid_ack_p1   <= 1'b0;
            r_host_ack_p1  <= 1'b0;
            r_mem_en_p1    <= 1'b0;
            r_mem_we_p1    <= 1'b0;
            r_mem_addr_p1  <= '0;
            r_mem_wdata_p1 <= '0;
            r_host_wait    <= '0;
        end else begin
            // p1: grant decision registered onto the ack and VRAM pins
            r_vid_ack_p1  <= w_grant_vid;
            r_host_ack_p1 <= w_grant_host;
            r_mem_en_p1   <= w_grant_vid || w_grant_host;
            if (w_grant_vid) begin
                r_mem_we_p1    <= 1'b0;
                r_mem_addr_p1  <= vid_addr_i;
                r_mem_wdata_p1 <= '0;
            end else if (w_grant_host) begin
                r_mem_we_p1    <= host_we_i;
                r_mem_addr_p1  <= host_addr_i;
                r_mem_wdata_p1 <= host_we_i ? host_wdata_i : '0;
            end else begin
                r_mem_we_p1    <= 1'b0;
            end

            if (!host_req_i || w_grant_host || r_host_ack_p1) begin
                r_host_wait <= '0;
            end else begin
                r_host_wait <= sat_inc(r_host_wait);
            end
        end
    end

    vram_ret_pipe #(
        .DW (DW)
    ) u_ret_pipe (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .own_i         (w_own),
        .mem_rdata_i   (mem_rdata_i),
        .vid_rvalid_o  (vid_rvalid_o),
        .vid_rdata_o   (vid_rdata_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o)
    );

    assign vid_ack_o   = r_vid_ack_p1;
    assign host_ack_o  = r_host_ack_p1;
    assign mem_en_o    = r_mem_en_p1;
    assign mem_we_o    = r_mem_we_p1;
    assign mem_addr_o  = r_mem_addr_p1;
    assign mem_wdata_o = r_mem_wdata_p1;
    assign host_wait_o = r_host_wait;

endmodule : vram_arbiter

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Bench for vram_arbiter with a behavioural single-port synchronous VRAM whose
// words initially hold their own address. Expected read returns are queued
// (data and return cycle) at the moment a request is acked and retired by a
// monitor when the matching rvalid pulse appears.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int HMW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [7:0]    host_wait;

    vram_arbiter #(
        .AW            (AW),
        .DW            (DW),
        .HOST_MAX_WAIT (HMW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .vid_req_i     (vid_req),
        .vid_addr_i    (vid_addr),
        .vid_ack_o     (vid_ack),
        .vid_rvalid_o  (vid_rvalid),
        .vid_rdata_o   (vid_rdata),
        .host_req_i    (host_req),
        .host_we_i     (host_we),
        .host_addr_i   (host_addr),
        .host_wdata_i  (host_wdata),
        .host_ack_o    (host_ack),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .host_wait_o   (host_wait)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural VRAM: word i initially holds i.
    logic [DW-1:0] ram [0:4095];
    logic          ram_init = 1'b1;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 16'(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    exp_t vq[$];
    exp_t hq[$];

    typedef struct {
        bit            is_vid;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t tbl[9];

    int checks   = 0;
    int failures = 0;

    int v_last, v_miss, v_miss_cyc;
    int h_ack, h_peak, h_ack2;
    int starve_acks;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic note_fail(input string nm, input int req_cyc);
        checks++;
        failures++;
        $display("FAIL %s actual=none required=event by cycle %0d (now %0d)", nm, req_cyc, cyc);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (vid_rvalid) begin
                if (vq.size() == 0) begin
                    note_fail("vid_rvalid_unexpected", cyc);
                end else begin
                    e = vq.pop_front();
                    check("vid_rdata", 32'(vid_rdata), 32'(e.d));
                    check("vid_latency", 32'(cyc), 32'(e.c));
                end
            end
            while (vq.size() > 0 && vq[0].c < cyc) begin
                note_fail("vid_rvalid_missing", vq[0].c);
                void'(vq.pop_front());
            end
            if (host_rvalid) begin
                if (hq.size() == 0) begin
                    note_fail("host_rvalid_unexpected", cyc);
                end else begin
                    e = hq.pop_front();
                    check("host_rdata", 32'(host_rdata), 32'(e.d));
                    check("host_latency", 32'(cyc), 32'(e.c));
                end
            end
            while (hq.size() > 0 && hq[0].c < cyc) begin
                note_fail("host_rvalid_missing", hq[0].c);
                void'(hq.pop_front());
            end
        end
    endtask

    // Present n consecutive video reads starting at 'start', holding each
    // address until it is acked. Expected data is the address itself unless
    // use_exp supplies an explicit value.
    task automatic vid_stream(input logic [AW-1:0] start, input int n, input bit use_exp,
                              input logic [DW-1:0] exp_d, output int last_ack,
                              output int miss, output int miss_cyc);
        int            idx   = 0;
        int            guard = 0;
        logic [AW-1:0] a;
        exp_t          e;
        last_ack = -1;
        miss     = 0;
        miss_cyc = -1;
        while (idx < n && guard < n + 50) begin
            a        = start + AW'(idx);
            vid_req  = 1'b1;
            vid_addr = a;
            @(posedge clk);
            #1;
            guard++;
            if (vid_ack) begin
                check("vid_mem_en", 32'(mem_en), 32'd1);
                check("vid_mem_addr", 32'(mem_addr), 32'(a));
                check("vid_mem_we", 32'(mem_we), 32'd0);
                e.d = use_exp ? exp_d : {4'h0, a};
                e.c = cyc + 2;
                vq.push_back(e);
                last_ack = cyc;
                idx++;
            end else begin
                miss++;
                miss_cyc = cyc;
            end
        end
        vid_req = 1'b0;
        if (idx < n) note_fail("vid_ack_timeout", cyc);
    endtask

    // Present one host access and hold it until acked.
    task automatic host_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input logic [DW-1:0] exp_d, input bit push,
                               output int ack_cyc, output int peak);
        bit   got = 0;
        exp_t e;
        ack_cyc    = -1;
        peak       = 0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = wd;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (int'(host_wait) > peak) peak = int'(host_wait);
            if (host_ack) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            ack_cyc = cyc;
            check("host_mem_en", 32'(mem_en), 32'd1);
            check("host_mem_addr", 32'(mem_addr), 32'(a));
            check("host_mem_we", 32'(mem_we), 32'(we));
            check("host_mem_wdata", 32'(mem_wdata), we ? 32'(wd) : 32'd0);
            if (push && !we) begin
                e.d = exp_d;
                e.c = cyc + 2;
                hq.push_back(e);
            end
        end else begin
            note_fail("host_ack_timeout", cyc);
        end
        host_req = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 12'h200, 16'h1234, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 12'h200, 16'h0000, 16'h1234};
        tbl[2] = '{1'b1, 1'b0, 12'h200, 16'h0000, 16'h1234};
        tbl[3] = '{1'b1, 1'b0, 12'h005, 16'h0000, 16'h0005};
        tbl[4] = '{1'b0, 1'b1, 12'h005, 16'hA5A5, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 12'h005, 16'h0000, 16'hA5A5};
        tbl[6] = '{1'b0, 1'b0, 12'hFFF, 16'h0000, 16'h0FFF};
        tbl[7] = '{1'b0, 1'b1, 12'hFFF, 16'hFFFF, 16'h0000};
        tbl[8] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 16'hFFFF};

        fork
            begin
                #500000;
                $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
                $fatal(1, "watchdog expired");
            end
        join_none
        fork
            monitor();
        join_none

        // Reset with both requesters active: reset must win.
        rst        = 1'b1;
        vid_req    = 1'b1;
        vid_addr   = 12'hABC;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 12'h123;
        host_wdata = 16'h5555;
        @(posedge clk);
        #1;
        ram_init = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_vid_ack", 32'(vid_ack), 32'd0);
        check("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
        check("rst_vid_rdata", 32'(vid_rdata), 32'd0);
        check("rst_host_ack", 32'(host_ack), 32'd0);
        check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_host_rdata", 32'(host_rdata), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_host_wait", 32'(host_wait), 32'd0);
        vid_req  = 1'b0;
        host_req = 1'b0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Host read in flight when reset hits: its return must be dropped.
        host_access(1'b0, 12'h010, 16'h0000, 16'h0010, 1'b0, h_ack, h_peak);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstfl_host_ack", 32'(host_ack), 32'd0);
        check("rstfl_mem_en", 32'(mem_en), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rstfl_no_host_rvalid", 32'(host_rvalid), 32'd0);
        end

        // Video streaming 0x000..0x00F, one access per cycle.
        vid_stream(12'h000, 16, 1'b0, 16'h0000, v_last, v_miss, v_miss_cyc);
        check("stream_no_stall", 32'(v_miss), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Table of single accesses, each waiting for its own ack.
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].is_vid) begin
                vid_stream(tbl[i].addr, 1, 1'b1, tbl[i].exp_d, v_last, v_miss, v_miss_cyc);
            end else begin
                host_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_d, 1'b1,
                            h_ack, h_peak);
            end
        end
        repeat (3) @(posedge clk);
        #1;

        // Collision: host write while video streams four words.
        fork
            vid_stream(12'h020, 4, 1'b0, 16'h0000, v_last, v_miss, v_miss_cyc);
            host_access(1'b1, 12'h123, 16'hBEEF, 16'h0000, 1'b1, h_ack, h_peak);
        join
        check("coll_wait_peak", 32'(h_peak), 32'd4);
        check("coll_ack_first_idle", 32'(h_ack), 32'(v_last + 1));
        host_access(1'b0, 12'h123, 16'h0000, 16'hBEEF, 1'b1, h_ack, h_peak);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back host reads with no video traffic.
        host_access(1'b0, 12'h010, 16'h0000, 16'h0010, 1'b1, h_ack, h_peak);
        host_access(1'b0, 12'h011, 16'h0000, 16'h0011, 1'b1, h_ack2, h_peak);
        check("b2b_slot_gap", 32'(h_ack2 - h_ack), 32'd2);
        repeat (3) @(posedge clk);
        #1;

`ifdef OGEGE_VRAM_FAIR_EN
        // Continuous video with a pending host read: host forced in at wait=HMW.
        fork
            vid_stream(12'h300, 20, 1'b0, 16'h0000, v_last, v_miss, v_miss_cyc);
            host_access(1'b0, 12'h400, 16'h0000, 16'h0400, 1'b1, h_ack, h_peak);
        join
        check("fair_wait_peak", 32'(h_peak), 32'(HMW));
        check("fair_vid_missed", 32'(v_miss), 32'd1);
        check("fair_host_slot", 32'(v_miss_cyc), 32'(h_ack));
`else
        // Continuous video with a pending host read: host starves, counter sticks.
        starve_acks = 0;
        fork
            vid_stream(12'h600, 300, 1'b0, 16'h0000, v_last, v_miss, v_miss_cyc);
            begin
                host_req  = 1'b1;
                host_we   = 1'b0;
                host_addr = 12'h400;
                repeat (300) begin
                    @(posedge clk);
                    #1;
                    if (host_ack) starve_acks++;
                end
            end
        join
        check("starve_no_ack", 32'(starve_acks), 32'd0);
        check("starve_wait_sat", 32'(host_wait), 32'd255);
        check("starve_vid_no_stall", 32'(v_miss), 32'd0);
        host_access(1'b0, 12'h400, 16'h0000, 16'h0400, 1'b1, h_ack, h_peak);
`endif

        repeat (6) @(posedge clk);
        #1;
        check("vid_queue_drained", 32'(vq.size()), 32'd0);
        check("host_queue_drained", 32'(hq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vram_arbiter
